// File: rtl/program_counter_nest.sv
// program_counter_nest
// Instruction word-address generator for the AP instruction path. It advances
// sequentially through the program, stalls at each cache-refill window
// boundary, jumps to interrupt vectors, and returns through a small LIFO
// return-address stack, so interrupts can nest.
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   ins_inp_valid   : current instruction consumed, request advance
//   ins_cache_rdy   : cache can accept a new address
//   load_times      : number of cache windows loaded so far
//   int_req         : interrupt pulse, jmp_addr_pc sampled with it
//   jmp_addr_pc     : interrupt target byte address
//   ret_req         : return-from-interrupt pulse
//   addr_ins        : registered instruction word address
//   redirect        : one-cycle pulse after a jump or return took effect
//   window_stall    : addr_ins is parked on the current window boundary
//   ins_finish      : program end reached (sticky until reset)
//   stack_level     : current interrupt nesting depth
//   stack_ovf       : sticky, interrupt arrived while the stack was full
//   stack_unf       : sticky, return arrived while the stack was empty
//   retire_cnt      : retired-instruction counter (only with PC_RETIRE_CNT_EN)
//
// Optional build macro: PC_RETIRE_CNT_EN adds the retire_cnt output.
// SP_WIDTH must satisfy 2**SP_WIDTH > RAS_DEPTH.

module program_counter_nest #(
  parameter int ADDR_WIDTH_MEM  = 16,
  parameter int ISA_DEPTH       = 64,
  parameter int TOTAL_ISA_DEPTH = 128,
  parameter int DDR_ADDR_WIDTH  = 28,
  parameter int JMP_SHIFT       = 3,
  parameter int RAS_DEPTH       = 4,
  parameter int SP_WIDTH        = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ins_inp_valid,
  input  logic                      ins_cache_rdy,
  input  logic [9:0]                load_times,
  input  logic                      int_req,
  input  logic [DDR_ADDR_WIDTH-1:0] jmp_addr_pc,
  input  logic                      ret_req,
  output logic [ADDR_WIDTH_MEM-1:0] addr_ins,
  output logic                      redirect,
  output logic                      window_stall,
  output logic                      ins_finish,
  output logic [SP_WIDTH-1:0]       stack_level,
  output logic                      stack_ovf,
  output logic                      stack_unf
`ifdef PC_RETIRE_CNT_EN
  ,output logic [31:0]              retire_cnt
`endif
);

  localparam int AW = ADDR_WIDTH_MEM;
  // Compare width wide enough for the 26-bit window product, the address and
  // the program length; one spare bit so TOTAL_ISA_DEPTH == 2**AW still fits.
  localparam int CW = (AW > 26 ? AW : 26) + 1;
  // Jump vector is widened first so that a narrow DDR address zero-extends
  // into the word address instead of under-running the slice.
  localparam int JW = (DDR_ADDR_WIDTH > AW + JMP_SHIFT) ? DDR_ADDR_WIDTH : AW + JMP_SHIFT;
  localparam int RAS_SLOTS = 2 ** SP_WIDTH;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // ---------------------------------------------------------------------------
  // Address compares
  // ---------------------------------------------------------------------------
  logic [25:0]   win_bound;
  logic [CW-1:0] addr_x, bound_x, total_x;
  logic          at_bound, below_total, at_total;
  logic [AW-1:0] addr_inc;

  assign win_bound   = 26'(load_times) * 26'(ISA_DEPTH);
  assign addr_x      = CW'(addr_ins);
  assign bound_x     = CW'(win_bound);
  assign total_x     = CW'(TOTAL_ISA_DEPTH);
  assign at_bound    = (addr_x == bound_x);
  assign below_total = (addr_x <  total_x);
  assign at_total    = (addr_x == total_x);
  assign addr_inc    = addr_ins + AW'(1);   // wraps modulo 2**AW

  assign window_stall = (state == ST_RUN) && at_bound && below_total;
  assign ins_finish   = (state == ST_HALT);   // HALT is terminal, so sticky

  // ---------------------------------------------------------------------------
  // Jump target: byte address -> word address
  // ---------------------------------------------------------------------------
  logic [JW-1:0] jmp_ext;
  logic [AW-1:0] jmp_target;

  assign jmp_ext    = JW'(jmp_addr_pc) >> JMP_SHIFT;
  assign jmp_target = jmp_ext[AW-1:0];

  // ---------------------------------------------------------------------------
  // Return-address stack. Storage is sized to the full pointer range so any
  // pointer value indexes a real slot; only the low RAS_DEPTH slots are used.
  // ---------------------------------------------------------------------------
  logic [AW-1:0] ras [RAS_SLOTS];
  logic          stack_full, stack_empty;
  logic [SP_WIDTH-1:0] sp_top;

  assign stack_full  = (stack_level == SP_WIDTH'(RAS_DEPTH));
  assign stack_empty = (stack_level == '0);
  assign sp_top      = stack_level - SP_WIDTH'(1);

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  logic do_push, do_pop, do_adv, set_ovf, set_unf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_START;
    else     state <= state_nxt;
  end

  // One action per cycle: int_req > ret_req > advance; losers are dropped.
  always_comb begin
    state_nxt = state;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    do_adv    = 1'b0;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;
    case (state)
      ST_START: state_nxt = ST_RUN;
      ST_RUN: begin
        if (at_total) begin
          // Program end reached: retire into HALT, no further actions.
          state_nxt = ST_HALT;
        end else if (int_req) begin
          if (stack_full) set_ovf = 1'b1;
          else            do_push = 1'b1;
        end else if (ret_req) begin
          if (stack_empty) set_unf = 1'b1;
          else             do_pop  = 1'b1;
        end else if (ins_inp_valid && ins_cache_rdy && below_total && !at_bound) begin
          do_adv = 1'b1;
        end
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_START;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_ins    <= '0;
      redirect    <= 1'b0;
      stack_level <= '0;
      stack_ovf   <= 1'b0;
      stack_unf   <= 1'b0;
    end else begin
      redirect <= do_push | do_pop;
      if (do_push) begin
        addr_ins    <= jmp_target;
        stack_level <= stack_level + SP_WIDTH'(1);
      end else if (do_pop) begin
        addr_ins    <= ras[sp_top];
        stack_level <= sp_top;
      end else if (do_adv) begin
        addr_ins    <= addr_inc;
      end
      if (set_ovf) stack_ovf <= 1'b1;
      if (set_unf) stack_unf <= 1'b1;
    end
  end

  // Stack contents are don't-care after reset, so no reset on the storage.
  always_ff @(posedge clk) begin
    if (do_push) ras[stack_level] <= addr_inc;
  end

`ifdef PC_RETIRE_CNT_EN
  // Counts sequential retirements and completed returns; free-running wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  retire_cnt <= '0;
    else if (do_adv | do_pop) retire_cnt <= retire_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_program_counter_nest.sv
// Directed bench for program_counter_nest (RAS_DEPTH=2, SP_WIDTH=2).
// Table vectors are applied one per clock; outputs are sampled 1 time unit
// after the rising edge.

module tb_program_counter_nest;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        v   = 1'b0;
  logic        rdy = 1'b0;
  logic [9:0]  lt  = '0;
  logic        irq = 1'b0;
  logic [27:0] jmp = '0;
  logic        ret = 1'b0;

  logic [15:0] addr_ins;
  logic        redirect, window_stall, ins_finish, stack_ovf, stack_unf;
  logic [1:0]  stack_level;
`ifdef PC_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  program_counter_nest #(
    .ADDR_WIDTH_MEM(16), .ISA_DEPTH(64), .TOTAL_ISA_DEPTH(128),
    .DDR_ADDR_WIDTH(28), .JMP_SHIFT(3), .RAS_DEPTH(2), .SP_WIDTH(2)
  ) dut (
    .clk(clk), .rst(rst),
    .ins_inp_valid(v), .ins_cache_rdy(rdy), .load_times(lt),
    .int_req(irq), .jmp_addr_pc(jmp), .ret_req(ret),
    .addr_ins(addr_ins), .redirect(redirect), .window_stall(window_stall),
    .ins_finish(ins_finish), .stack_level(stack_level),
    .stack_ovf(stack_ovf), .stack_unf(stack_unf)
`ifdef PC_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        v, rdy;
    logic [9:0]  lt;
    logic        irq;
    logic [27:0] jmp;
    logic        ret;
    logic [15:0] addr;
    logic        redir, stall;
    logic [1:0]  lvl;
    logic        ovf, unf, fin;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic v_, input logic rdy_, input logic [9:0] lt_,
                              input logic irq_, input logic [27:0] jmp_, input logic ret_,
                              input logic [15:0] a_, input logic rd_, input logic st_,
                              input logic [1:0] lv_, input logic ov_, input logic un_,
                              input logic fi_);
    vec_t r;
    r.v = v_; r.rdy = rdy_; r.lt = lt_; r.irq = irq_; r.jmp = jmp_; r.ret = ret_;
    r.addr = a_; r.redir = rd_; r.stall = st_; r.lvl = lv_;
    r.ovf = ov_; r.unf = un_; r.fin = fi_;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [15:0] a, input logic rd,
                            input logic st, input logic [1:0] lv, input logic ov,
                            input logic un, input logic fi);
    chk({tag, ".addr_ins"},     32'(addr_ins),     32'(a));
    chk({tag, ".redirect"},     32'(redirect),     32'(rd));
    chk({tag, ".window_stall"}, 32'(window_stall), 32'(st));
    chk({tag, ".stack_level"},  32'(stack_level),  32'(lv));
    chk({tag, ".stack_ovf"},    32'(stack_ovf),    32'(ov));
    chk({tag, ".stack_unf"},    32'(stack_unf),    32'(un));
    chk({tag, ".ins_finish"},   32'(ins_finish),   32'(fi));
  endtask

  task automatic idle_inputs();
    v = 1'b0; irq = 1'b0; ret = 1'b0; jmp = '0;
  endtask

  task automatic run_tbl(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i].v; rdy = tbl[i].rdy; lt = tbl[i].lt;
      irq = tbl[i].irq; jmp = tbl[i].jmp; ret = tbl[i].ret;
      @(posedge clk); #1;
      check_outs($sformatf("%s[%0d]", tag, i), tbl[i].addr, tbl[i].redir, tbl[i].stall,
                 tbl[i].lvl, tbl[i].ovf, tbl[i].unf, tbl[i].fin);
    end
    tbl.delete();
    idle_inputs();
  endtask

  // Reset pulse; optionally spend the START cycle so the FSM is in RUN after.
  task automatic do_reset(input bit to_run);
    idle_inputs();
    #2 rst = 1'b1;
    #1 check_outs("reset", 16'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    if (to_run) begin
      @(posedge clk); #1;
    end
  endtask

  // n consecutive advances from address 'from'; checks every step.
  task automatic adv_n(input int n, input logic [9:0] lt_, input int from);
    v = 1'b1; rdy = 1'b1; lt = lt_;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk($sformatf("adv[%0d].addr_ins", from + i + 1), 32'(addr_ins), 32'(from + i + 1));
      chk($sformatf("adv[%0d].ins_finish", from + i + 1), 32'(ins_finish), 32'd0);
    end
    v = 1'b0;
  endtask

  initial begin
    // ---- sequential advance; first post-reset cycle (START) ignores requests
    do_reset(1'b0);
    tbl.push_back(mk(1,1,2, 0,28'h0,0,  16'd0, 0,0,2'd0, 0,0,0));
    tbl.push_back(mk(1,1,2, 0,28'h0,0,  16'd1, 0,0,2'd0, 0,0,0));
    tbl.push_back(mk(0,1,2, 0,28'h0,0,  16'd1, 0,0,2'd0, 0,0,0));
    tbl.push_back(mk(1,1,2, 0,28'h0,0,  16'd2, 0,0,2'd0, 0,0,0));
    tbl.push_back(mk(1,1,2, 0,28'h0,0,  16'd3, 0,0,2'd0, 0,0,0));
    tbl.push_back(mk(1,1,2, 0,28'h0,0,  16'd4, 0,0,2'd0, 0,0,0));
    tbl.push_back(mk(1,0,2, 0,28'h0,0,  16'd4, 0,0,2'd0, 0,0,0));
    run_tbl("seq");

    // ---- window boundary stall at 64 with load_times=1, release with 2
    adv_n(60, 10'd1, 4);
    tbl.push_back(mk(1,1,1, 0,28'h0,0,  16'd64, 0,1,2'd0, 0,0,0));
    tbl.push_back(mk(1,1,1, 0,28'h0,0,  16'd64, 0,1,2'd0, 0,0,0));
    tbl.push_back(mk(0,1,2, 0,28'h0,0,  16'd64, 0,0,2'd0, 0,0,0));
    tbl.push_back(mk(1,1,2, 0,28'h0,0,  16'd65, 0,0,2'd0, 0,0,0));
    run_tbl("win");

    // ---- nested interrupts, overflow, LIFO returns, underflow
    do_reset(1'b1);
    adv_n(10, 10'd2, 0);
    tbl.push_back(mk(0,1,2, 1,28'h100,0, 16'd32, 1,0,2'd1, 0,0,0));
    tbl.push_back(mk(0,1,2, 0,28'h0,0,   16'd32, 0,0,2'd1, 0,0,0));
    tbl.push_back(mk(0,1,2, 1,28'h200,0, 16'd64, 1,0,2'd2, 0,0,0));
    tbl.push_back(mk(0,1,2, 1,28'h300,0, 16'd64, 0,0,2'd2, 1,0,0));
    tbl.push_back(mk(0,1,2, 0,28'h0,1,   16'd33, 1,0,2'd1, 1,0,0));
    tbl.push_back(mk(0,1,2, 0,28'h0,1,   16'd11, 1,0,2'd0, 1,0,0));
    tbl.push_back(mk(0,1,2, 0,28'h0,1,   16'd11, 0,0,2'd0, 1,1,0));
    tbl.push_back(mk(1,1,2, 0,28'h0,0,   16'd12, 0,0,2'd0, 1,1,0));
    run_tbl("nest");

    // ---- priority: int beats ret, ret beats advance
    do_reset(1'b1);
    adv_n(5, 10'd2, 0);
    tbl.push_back(mk(0,1,2, 1,28'h40,1, 16'd8, 1,0,2'd1, 0,0,0));
    tbl.push_back(mk(1,1,2, 0,28'h0,1,  16'd6, 1,0,2'd0, 0,0,0));
    tbl.push_back(mk(1,1,2, 0,28'h0,0,  16'd7, 0,0,2'd0, 0,0,0));
    run_tbl("prio");

    // ---- program end at 128, HALT ignores requests
    adv_n(121, 10'd2, 7);
    tbl.push_back(mk(0,1,2, 0,28'h0,0,   16'd128, 0,0,2'd0, 0,0,1));
    tbl.push_back(mk(0,1,2, 1,28'h100,0, 16'd128, 0,0,2'd0, 0,0,1));
    tbl.push_back(mk(0,1,2, 0,28'h0,1,   16'd128, 0,0,2'd0, 0,0,1));
    tbl.push_back(mk(1,1,2, 0,28'h0,0,   16'd128, 0,0,2'd0, 0,0,1));
    run_tbl("halt");

    // ---- asynchronous reset mid-stream clears outputs without a clock edge
    #2 rst = 1'b1;
    #1 check_outs("async_rst", 16'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1 rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
